neuron_seq: RTL
===============

NEURON_SEQ -- requirements
Module: neuron_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 15; all data ports are [WIDTH:0], signed two's-complement.
REQ-002 SHALL have parameter DEPTH, default 4; job FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameter START_CYC, default 2; number of cycles nrn_rst is held high per launch, minimum 1.
REQ-004 SHALL have parameter TIMEOUT, default 64; RUN-state cycle limit, used only under NEURON_SEQ_TIMEOUT_EN.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 in_valid  in  1  job offered.
REQ-008 in_ready  out  1  job FIFO not full.
REQ-009 in_x, in_y, in_z  in  WIDTH+1 each  job operands.
REQ-010 nrn_rst  out  1  start/reset strobe to the neuron datapath.
REQ-011 nrn_x, nrn_y, nrn_z  out  WIDTH+1 each  operands to the neuron.
REQ-012 nrn_complete  in  1  neuron done flag.
REQ-013 nrn_sin, nrn_cos, nrn_lin  in  WIDTH+1 each  neuron hyperbolic sine, cosine and linear result.
REQ-014 out_valid  out  1  result held.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out_sin, out_cos, out_lin  out  WIDTH+1 each  captured results.
REQ-017 out_err  out  1  result produced by timeout.
REQ-018 busy  out  1  high when state is not IDLE or FIFO is non-empty.

Function
REQ-019 Job FIFO SHALL push on in_valid&&in_ready; in_ready = !full; no fall-through, so a pushed entry is first poppable the cycle after the push.
REQ-020 When full, push SHALL be refused even if a pop occurs the same cycle; a simultaneous push and pop when neither full nor empty SHALL leave the count unchanged.
REQ-021 FSM states SHALL be IDLE, LAUNCH, RUN and HOLD.
REQ-022 IDLE with FIFO non-empty SHALL pop the head into nrn_x/y/z, set nrn_rst=1 and go to LAUNCH; with FIFO empty it SHALL stay in IDLE.
REQ-023 LAUNCH SHALL hold nrn_rst=1 for exactly START_CYC cycles, then set nrn_rst=0 and go to RUN.
REQ-024 nrn_x/y/z SHALL stay constant from the pop until the next pop.
REQ-025 RUN SHALL ignore nrn_complete in its first cycle; in any later cycle, sampled nrn_complete=1 SHALL load out_sin/out_cos/out_lin from nrn_sin/nrn_cos/nrn_lin, set out_valid=1 and out_err=0, and go to HOLD.
REQ-026 HOLD SHALL keep outputs stable while out_valid&&!out_ready.
REQ-027 On out_valid&&out_ready, HOLD SHALL clear out_valid and go to IDLE; no new launch SHALL occur before the handshake completes.
REQ-028 Latency from pop to out_valid SHALL be START_CYC + 1 + N cycles, where N is the RUN cycle in which complete is first sampled (N >= 1, counting from 0).
REQ-029 Results SHALL be delivered in FIFO order, one per job, with no drops or duplicates.

Reset
REQ-030 While reset=1 the block SHALL set: state IDLE, FIFO empty, in_ready=0, nrn_rst=1, nrn_x/y/z=0, out_valid=0, out_sin/out_cos/out_lin=0, out_err=0, busy=0.
REQ-031 in_ready SHALL rise and nrn_rst SHALL fall on the first edge with reset=0.
REQ-032 Reset asserted mid-operation (any state) SHALL abort the job, discard FIFO contents and any held result, and apply REQ-030 on the next edge.

Configuration
REQ-033 With NEURON_SEQ_TIMEOUT_EN defined, RUN SHALL count cycles; at TIMEOUT cycles without complete it SHALL load all results to 0, set out_err=1 and out_valid=1, and go to HOLD.
REQ-034 With NEURON_SEQ_TIMEOUT_EN undefined, RUN SHALL wait indefinitely, out_err SHALL be constant 0, and no timeout counter SHALL be synthesized.

Verification
REQ-035 Reset release, then push (x=0x0100, y=0x0080, z=0x0040) -> nrn_x/y/z carry these values, nrn_rst is high exactly 2 cycles, and out_valid rises 1 cycle after complete is sampled in RUN.
REQ-036 Push 5 jobs back-to-back with DEPTH=4 and no pops -> in_ready drops after the 4th push; the 5th is accepted only after a pop.
REQ-037 Hold out_ready=0 for 10 cycles in HOLD -> out_* stable, nrn_rst stays 0, no new pop; out_ready=1 -> next launch on the following cycle.
REQ-038 Assert nrn_complete=1 during LAUNCH and the first RUN cycle only -> no capture; the block stays in RUN.
REQ-039 With NEURON_SEQ_TIMEOUT_EN, never assert complete -> after 64 RUN cycles, out_valid=1, out_err=1, results=0; without the macro, out_valid stays 0.
REQ-040 Assert reset for 1 cycle during RUN with 3 jobs queued -> all outputs at reset values, FIFO empty, no result emitted.

Source files
------------

// File: rtl/neuron_seq.sv
// neuron_seq: job FIFO feeding a launch/run/hold sequencer for an iterative neuron datapath.
// Define NEURON_SEQ_TIMEOUT_EN to add a RUN-state watchdog that emits a zeroed result with out_err set.
module neuron_seq #(
  parameter int WIDTH     = 15,
  parameter int DEPTH     = 4,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [WIDTH:0] in_x,
  input  logic signed [WIDTH:0] in_y,
  input  logic signed [WIDTH:0] in_z,
  output logic               nrn_rst,
  output logic signed [WIDTH:0] nrn_x,
  output logic signed [WIDTH:0] nrn_y,
  output logic signed [WIDTH:0] nrn_z,
  input  logic               nrn_complete,
  input  logic signed [WIDTH:0] nrn_sin,
  input  logic signed [WIDTH:0] nrn_cos,
  input  logic signed [WIDTH:0] nrn_lin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [WIDTH:0] out_sin,
  output logic signed [WIDTH:0] out_cos,
  output logic signed [WIDTH:0] out_lin,
  output logic               out_err,
  output logic               busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LCW = $clog2(START_CYC + 1);
  localparam int EW  = 3 * (WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, HOLD} state_t;

  state_t         state, state_nxt;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [LCW-1:0] launch_cnt;
  logic           alive;
  logic           run_first;
  logic           full, empty, push, pop, capture, timeout;

  // alive stays low through reset so in_ready is held off and nrn_rst held on
  always_comb begin
    full      = (count == (AW+1)'(DEPTH));
    empty     = (count == '0);
    in_ready  = alive && !full;
    push      = in_valid && in_ready;
    pop       = (state == IDLE) && !empty;
    capture   = (state == RUN) && !run_first && nrn_complete;
    nrn_rst   = !alive || (state == LAUNCH);
    out_valid = (state == HOLD);
    busy      = (state != IDLE) || !empty;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = LAUNCH;
      LAUNCH:  if (launch_cnt == LCW'(START_CYC - 1)) state_nxt = RUN;
      RUN:     if (capture || timeout) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_z};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alive      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      launch_cnt <= '0;
      run_first  <= 1'b1;
      nrn_x      <= '0;
      nrn_y      <= '0;
      nrn_z      <= '0;
      out_sin    <= '0;
      out_cos    <= '0;
      out_lin    <= '0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) {nrn_x, nrn_y, nrn_z} <= mem[rd_ptr];
      launch_cnt <= (state == LAUNCH) ? launch_cnt + 1'b1 : '0;
      // the first RUN cycle is blind to nrn_complete while the neuron leaves reset
      run_first  <= (state != RUN);
      if (capture) begin
        out_sin <= nrn_sin;
        out_cos <= nrn_cos;
        out_lin <= nrn_lin;
      end else if (timeout) begin
        out_sin <= '0;
        out_cos <= '0;
        out_lin <= '0;
      end
    end
  end

`ifdef NEURON_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] run_cnt;

  assign timeout = (state == RUN) && !capture && (run_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
      out_err <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
      if (capture)      out_err <= 1'b0;
      else if (timeout) out_err <= 1'b1;
    end
  end
`else
  // without the watchdog RUN waits forever; TIMEOUT only matters when it is built in
  assign timeout = (TIMEOUT < 0);
  assign out_err = 1'b0;
`endif

endmodule
